csr_counter: RTL and testbench



---
 rtl/csr_counter.sv | 62 ++++++
 tb/tb_csr_counter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/csr_counter.sv
// csr_counter: RISC-V cycle/instret performance-counter CSR unit with a registered,
// one-cycle-latency CSR read/modify port.
//   clk      clock
//   rstn     synchronous active-low reset
//   retired  one instruction retired this cycle
//   read     CSR access request this cycle
//   modify   00 none, 01 write, 10 set bits, 11 clear bits
//   wdata    operand for modify
//   addr     CSR address
//   rdata    pre-access value of the addressed CSR half, registered
//   valid    access accepted, registered
module csr_counter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        retired,
    input  logic        read,
    input  logic [1:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid
);
    logic [63:0] cyc_q, cyc_d, ins_q, ins_d;
    logic [31:0] rdata_q, rdata_d, old, nv;
    logic        valid_q, valid_d;
    logic [10:0] key;
    logic        hi, sel_ins, rw_hit, ro_hit, wr, acc;
    always_comb begin
        // addr[7] picks the high half, so it is dropped from the match key
        key = {addr[11:8], addr[6:0]};
        hi = addr[7];
        sel_ins = addr[1];
        rw_hit = read && (key == {4'hB, 7'h00} || key == {4'hB, 7'h02});
        ro_hit = read && (key == {4'hC, 7'h00} || key == {4'hC, 7'h01} || key == {4'hC, 7'h02});
        old = sel_ins ? (hi ? ins_q[63:32] : ins_q[31:0]) : (hi ? cyc_q[63:32] : cyc_q[31:0]);
        nv = modify == 2'b01 ? wdata : modify == 2'b10 ? (old | wdata) : (old & ~wdata);
        wr = rw_hit && modify != 2'b00;
        acc = rw_hit || (ro_hit && modify == 2'b00);
        cyc_d = cyc_q + 64'd1;
        ins_d = ins_q + {63'd0, retired};
        // a write replaces the increment of the written counter for this cycle
        if (wr && !sel_ins) cyc_d = hi ? {nv, cyc_q[31:0]} : {cyc_q[63:32], nv};
        if (wr && sel_ins) ins_d = hi ? {nv, ins_q[31:0]} : {ins_q[63:32], nv};
        rdata_d = acc ? old : 32'd0;
        valid_d = acc;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cyc_q   <= '0;
            ins_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end
    assign rdata = rdata_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_csr_counter.sv
// tb_csr_counter: randomized and directed checks of csr_counter against a behavioural model
module tb_csr_counter;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        retired = 1'b0;
    logic        read = 1'b0;
    logic [1:0]  modify = 2'b00;
    logic [31:0] wdata = '0;
    logic [11:0] addr = '0;
    logic [31:0] rdata;
    logic        valid;
    int          passed = 0;
    int          total = 0;
    logic [63:0] ctr [2];
    logic [31:0] exp_rd;
    logic        exp_v;
    logic [11:0] amap [10] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                               12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82};

    csr_counter dut (
        .clk(clk), .rstn(rstn), .retired(retired), .read(read), .modify(modify),
        .wdata(wdata), .addr(addr), .rdata(rdata), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic void dec(input logic [11:0] a, output bit hit, output bit rw,
                                output int k, output bit hi);
        hit = 1; rw = 0; k = 0; hi = 0;
        case (a)
            12'hB00: rw = 1;
            12'hB80: begin rw = 1; hi = 1; end
            12'hB02: begin rw = 1; k = 1; end
            12'hB82: begin rw = 1; k = 1; hi = 1; end
            12'hC00, 12'hC01: ;
            12'hC80, 12'hC81: hi = 1;
            12'hC02: k = 1;
            12'hC82: begin k = 1; hi = 1; end
            default: hit = 0;
        endcase
    endfunction

    task automatic step(input bit rn, input bit ret, input bit rd, input logic [1:0] md,
                        input logic [31:0] wd, input logic [11:0] ad);
        bit hit, rw, hi, wr;
        int k;
        logic [31:0] o, n;
        rstn = rn; retired = ret; read = rd; modify = md; wdata = wd; addr = ad;
        dec(ad, hit, rw, k, hi);
        hit = hit && rd;
        o = hi ? ctr[k][63:32] : ctr[k][31:0];
        if (!rn) begin
            ctr[0] = 0; ctr[1] = 0; exp_rd = 0; exp_v = 0;
        end else begin
            exp_v = hit && (rw || md == 2'b00);
            exp_rd = exp_v ? o : 32'd0;
            wr = hit && rw && md != 2'b00;
            n = md == 2'b01 ? wd : md == 2'b10 ? (o | wd) : (o & ~wd);
            if (!(wr && k == 0)) ctr[0] = ctr[0] + 1;
            if (ret && !(wr && k == 1)) ctr[1] = ctr[1] + 1;
            if (wr) begin
                if (hi) ctr[k][63:32] = n;
                else ctr[k][31:0] = n;
            end
        end
        @(posedge clk);
        #1;
        chk($sformatf("rdata@%h", ad), rdata, exp_rd);
        chk($sformatf("valid@%h", ad), {31'd0, valid}, {31'd0, exp_v});
    endtask

    initial begin
        ctr[0] = 0; ctr[1] = 0;
        repeat (3) step(0, 1, 0, 0, 0, 0);
        repeat (10) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 12'hC00);
        chk("cycle_after_10", rdata, 32'd10);
        step(1, 0, 1, 0, 0, 12'hC80);
        chk("cycleh_zero", rdata, 32'd0);
        repeat (5) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 12'hB02);
        chk("minstret_5", rdata, 32'd5);
        step(1, 0, 1, 0, 0, 12'hC02);
        chk("instret_5", rdata, 32'd5);
        step(1, 0, 1, 2'b01, 32'hFFFF_FFF0, 12'hB00);
        repeat (20) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 12'hC80);
        chk("carry_cycleh", rdata, 32'd1);
        step(1, 0, 1, 2'b01, 32'h0F, 12'hB02);
        step(1, 0, 1, 2'b10, 32'hF0, 12'hB02);
        step(1, 0, 1, 2'b11, 32'h0C, 12'hB02);
        step(1, 0, 1, 0, 0, 12'hB02);
        chk("setclr_F3", rdata, 32'hF3);
        step(1, 0, 1, 2'b01, 32'h1234, 12'hC00);
        chk("ro_write_valid", {31'd0, valid}, 32'd0);
        step(1, 0, 1, 2'b10, 32'h0, 12'hC02);
        step(1, 0, 1, 0, 0, 12'h300);
        chk("unmapped_valid", {31'd0, valid}, 32'd0);
        step(1, 1, 1, 2'b01, 32'h1234, 12'hB02);
        step(1, 0, 1, 0, 0, 12'hB02);
        chk("write_beats_retire", rdata, 32'h1234);
        step(1, 1, 1, 0, 0, 12'hC00);
        step(0, 1, 1, 0, 0, 12'hC00);
        chk("reset_discard", {31'd0, valid}, 32'd0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 12'hC02);
        chk("ins_after_reset", rdata, 32'd0);
        repeat (3000) begin
            logic [11:0] a;
            a = $urandom_range(0, 3) != 0 ? amap[$urandom_range(0, 9)] : 12'($urandom);
            step($urandom_range(0, 99) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0 ? 2'($urandom) : 2'b00,
                 $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
                 a);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
